// File: rtl/gcm_tag_verify_if.sv
`default_nettype none
// ============================================================================
// Module      : gcm_tag_verify_if
// Description : Bundle of the GCM tag-verify control, block-stream and
//               GHASH-multiplier signals. The slave modport is the sequencer
//               view; the master modport is the surrounding datapath view.
//               The tag_bytes member exists only when GCM_TAG_TRUNC_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface gcm_tag_verify_if #(
  parameter int LEN_W = 64
);
  logic             start;
  logic [127:0]     ek_y0;
  logic [127:0]     tag_in;
  logic [LEN_W-1:0] aad_bits;
  logic [LEN_W-1:0] ct_bits;
`ifdef GCM_TAG_TRUNC_EN
  logic [4:0]       tag_bytes;
`endif
  logic             blk_valid;
  logic             blk_ready;
  logic [127:0]     blk_data;
  logic             mul_start;
  logic [127:0]     mul_x;
  logic [127:0]     mul_y_prev;
  logic             mul_done;
  logic [127:0]     mul_y;
  logic             busy;
  logic             done;
  logic [127:0]     tag_out;
  logic             tag_ok;

  modport slave (
`ifdef GCM_TAG_TRUNC_EN
    input  tag_bytes,
`endif
    input  start, ek_y0, tag_in, aad_bits, ct_bits,
    input  blk_valid, blk_data, mul_done, mul_y,
    output blk_ready, mul_start, mul_x, mul_y_prev,
    output busy, done, tag_out, tag_ok
  );

  modport master (
`ifdef GCM_TAG_TRUNC_EN
    output tag_bytes,
`endif
    output start, ek_y0, tag_in, aad_bits, ct_bits,
    output blk_valid, blk_data, mul_done, mul_y,
    input  blk_ready, mul_start, mul_x, mul_y_prev,
    input  busy, done, tag_out, tag_ok
  );
endinterface
`default_nettype wire

// File: rtl/gcm_tag_verify.sv
`default_nettype none
// ============================================================================
// Module      : gcm_tag_verify
// Description : Receive-side GCM authentication sequencer. Feeds AAD and
//               ciphertext blocks (final partial block masked) and then the
//               length block to an external GHASH multiplier, forms
//               tag = GHASH ^ E(K,Y0) and compares it with the received tag.
//               Optional macro GCM_TAG_TRUNC_EN: adds tag_bytes (12..16) so
//               only the top 8*tag_bytes bits take part in the compare.
// Revision    : 1.0 - initial release
// ============================================================================
module gcm_tag_verify #(
  parameter int LEN_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  gcm_tag_verify_if.slave   bus_io
);

  localparam int CNT_W = LEN_W - 6;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_AAD_WAIT = 3'd1;
  localparam logic [2:0] S_AAD_MUL  = 3'd2;
  localparam logic [2:0] S_CT_WAIT  = 3'd3;
  localparam logic [2:0] S_CT_MUL   = 3'd4;
  localparam logic [2:0] S_LEN_MUL  = 3'd5;
  localparam logic [2:0] S_FIN      = 3'd6;

  logic [2:0]       state_q,  state_d;
  logic [127:0]     y_q,      y_d;
  logic [127:0]     ek_q,     ek_d;
  logic [127:0]     tagin_q,  tagin_d;
  logic [127:0]     mx_q,     mx_d;
  logic [127:0]     tag_q,    tag_d;
  logic [LEN_W-1:0] aad_q,    aad_d;
  logic [LEN_W-1:0] ct_q,     ct_d;
  logic [CNT_W-1:0] naad_q,   naad_d;
  logic [CNT_W-1:0] nct_q,    nct_d;
  logic             ms_q,     ms_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             ok_q,     ok_d;

  logic             w_ready;
  logic             w_in_aad;
  logic             w_last;
  logic [6:0]       w_rem;
  logic [127:0]     w_keep;
  logic [127:0]     w_tag;
  logic [127:0]     w_cmp_mask;
  logic             w_ok;
  logic [CNT_W-1:0] w_n_aad;
  logic [CNT_W-1:0] w_n_ct;

  // Length block: both lengths forced to 64 bits (truncate or zero-extend).
  function automatic logic [127:0] len_block(input logic [LEN_W-1:0] a,
                                             input logic [LEN_W-1:0] c);
    return {64'(a), 64'(c)};
  endfunction

  // Block counts are ceil(bits/128).
  assign w_n_aad  = {1'b0, bus_io.aad_bits[LEN_W-1:7]} + CNT_W'(|bus_io.aad_bits[6:0]);
  assign w_n_ct   = {1'b0, bus_io.ct_bits[LEN_W-1:7]}  + CNT_W'(|bus_io.ct_bits[6:0]);

  assign w_ready  = (state_q == S_AAD_WAIT) || (state_q == S_CT_WAIT);
  assign w_in_aad = (state_q == S_AAD_WAIT);
  assign w_last   = w_in_aad ? (naad_q == CNT_W'(1)) : (nct_q == CNT_W'(1));
  assign w_rem    = w_in_aad ? aad_q[6:0] : ct_q[6:0];
  // Only a final partial block is masked; its leading w_rem bits survive.
  assign w_keep   = (w_last && (w_rem != 7'd0)) ? ~({128{1'b1}} >> w_rem) : {128{1'b1}};
  assign w_tag    = y_q ^ ek_q;
  assign w_ok     = ((w_tag ^ tagin_q) & w_cmp_mask) == 128'd0;

`ifdef GCM_TAG_TRUNC_EN
  logic [4:0] tbytes_q, tbytes_d;

  // Compare window covers the top 8*tag_bytes bits; illegal sizes use all 128.
  always_comb begin
    w_cmp_mask = {128{1'b1}};
    if (tbytes_q >= 5'd12 && tbytes_q <= 5'd16)
      w_cmp_mask = {128{1'b1}} << (8'd128 - {tbytes_q, 3'b000});
  end
`else
  assign w_cmp_mask = {128{1'b1}};
`endif

  // Sequencer next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ek_d    = ek_q;
    tagin_d = tagin_q;
    mx_d    = mx_q;
    tag_d   = tag_q;
    aad_d   = aad_q;
    ct_d    = ct_q;
    naad_d  = naad_q;
    nct_d   = nct_q;
    ms_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
`ifdef GCM_TAG_TRUNC_EN
    tbytes_d = tbytes_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus_io.start) begin
          ek_d    = bus_io.ek_y0;
          tagin_d = bus_io.tag_in;
          aad_d   = bus_io.aad_bits;
          ct_d    = bus_io.ct_bits;
          naad_d  = w_n_aad;
          nct_d   = w_n_ct;
          y_d     = 128'd0;
          tag_d   = 128'd0;
          ok_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef GCM_TAG_TRUNC_EN
          tbytes_d = bus_io.tag_bytes;
`endif
          if (w_n_aad != '0) begin
            state_d = S_AAD_WAIT;
          end else if (w_n_ct != '0) begin
            state_d = S_CT_WAIT;
          end else begin
            state_d = S_LEN_MUL;
            ms_d    = 1'b1;
            mx_d    = len_block(bus_io.aad_bits, bus_io.ct_bits);
          end
        end
      end
      S_AAD_WAIT, S_CT_WAIT: begin
        if (bus_io.blk_valid) begin
          mx_d    = bus_io.blk_data & w_keep;
          ms_d    = 1'b1;
          state_d = w_in_aad ? S_AAD_MUL : S_CT_MUL;
        end
      end
      S_AAD_MUL: begin
        if (bus_io.mul_done) begin
          y_d    = bus_io.mul_y;
          naad_d = naad_q - CNT_W'(1);
          if (naad_q != CNT_W'(1)) begin
            state_d = S_AAD_WAIT;
          end else if (nct_q != '0) begin
            state_d = S_CT_WAIT;
          end else begin
            state_d = S_LEN_MUL;
            ms_d    = 1'b1;
            mx_d    = len_block(aad_q, ct_q);
          end
        end
      end
      S_CT_MUL: begin
        if (bus_io.mul_done) begin
          y_d   = bus_io.mul_y;
          nct_d = nct_q - CNT_W'(1);
          if (nct_q != CNT_W'(1)) begin
            state_d = S_CT_WAIT;
          end else begin
            state_d = S_LEN_MUL;
            ms_d    = 1'b1;
            mx_d    = len_block(aad_q, ct_q);
          end
        end
      end
      S_LEN_MUL: begin
        if (bus_io.mul_done) begin
          y_d     = bus_io.mul_y;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        tag_d   = w_tag;
        ok_d    = w_ok;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any message and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      ek_q    <= '0;
      tagin_q <= '0;
      mx_q    <= '0;
      tag_q   <= '0;
      aad_q   <= '0;
      ct_q    <= '0;
      naad_q  <= '0;
      nct_q   <= '0;
      ms_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
`ifdef GCM_TAG_TRUNC_EN
      tbytes_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ek_q    <= ek_d;
      tagin_q <= tagin_d;
      mx_q    <= mx_d;
      tag_q   <= tag_d;
      aad_q   <= aad_d;
      ct_q    <= ct_d;
      naad_q  <= naad_d;
      nct_q   <= nct_d;
      ms_q    <= ms_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
`ifdef GCM_TAG_TRUNC_EN
      tbytes_q <= tbytes_d;
`endif
    end
  end

  assign bus_io.blk_ready  = w_ready;
  assign bus_io.mul_start  = ms_q;
  assign bus_io.mul_x      = mx_q;
  assign bus_io.mul_y_prev = y_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.done       = done_q;
  assign bus_io.tag_out    = tag_q;
  assign bus_io.tag_ok     = ok_q;

endmodule
`default_nettype wire

// File: tb/tb_gcm_tag_verify.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcm_tag_verify
// Description : Self-checking bench for gcm_tag_verify. A behavioural GHASH
//               multiplier (or an XOR stub) answers mul_start; expected tags
//               come from a byte-level GCM reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcm_tag_verify;
  localparam int LEN_W = 64;
  localparam logic [127:0] C_H    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C_EK   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C_CT2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] C_TAG2 = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcm_tag_verify_if #(.LEN_W(LEN_W)) bus ();
  gcm_tag_verify #(.LEN_W(LEN_W)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // multiplier model configuration (written only by the initial block)
  int           mul_mode = 0;   // 0: GF(2^128) product with h_key, 1: XOR stub
  int           mul_lat  = 4;
  logic [127:0] h_key    = C_H;

  // monitor state (written only by the negedge process)
  int           m_cnt = 0;
  logic [127:0] m_res = '0;
  int           acc_cnt = 0, ms_cnt = 0, rdy_cnt = 0, done_cnt = 0, last_md_cyc = 0;
  logic [127:0] mx_log[$];

  // message storage: true (padded) blocks for the model, driven blocks for the DUT
  logic [127:0] aad_true[$], ct_true[$], drv_blks[$];

  // results of the last drive_msg call
  bit           res_tmo;
  int           res_lat;
  logic [127:0] res_tout;
  logic         res_tok, res_busy, res_again;

  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] mulf(input int mode, input logic [127:0] a, input logic [127:0] h);
    return (mode != 0) ? a : gf_mul(a, h);
  endfunction

  function automatic logic [127:0] ref_ghash(input int mode, input logic [127:0] h,
                                             input logic [63:0] ab, input logic [63:0] cb);
    logic [127:0] y;
    y = '0;
    foreach (aad_true[i]) y = mulf(mode, y ^ aad_true[i], h);
    foreach (ct_true[i])  y = mulf(mode, y ^ ct_true[i], h);
    y = mulf(mode, y ^ {ab, cb}, h);
    return y;
  endfunction

  // Multiplier model and monitors, evaluated away from the active edge.
  always @(negedge clk) begin
    bus.mul_done = 1'b0;
    if (!rst_n) m_cnt = 0;
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        bus.mul_done = 1'b1;
        bus.mul_y    = m_res;
        last_md_cyc  = cyc;
      end
    end
    if (bus.mul_start) begin
      ms_cnt = ms_cnt + 1;
      mx_log.push_back(bus.mul_x);
      m_res = mulf(mul_mode, bus.mul_x ^ bus.mul_y_prev, h_key);
      m_cnt = mul_lat;
    end
    if (bus.blk_valid && bus.blk_ready) acc_cnt = acc_cnt + 1;
    if (bus.blk_ready) rdy_cnt = rdy_cnt + 1;
    if (bus.done) done_cnt = done_cnt + 1;
  end

  task automatic add_phase(input int nbytes, input bit is_ct);
    logic [127:0] t, d;
    logic [7:0]   b;
    for (int i = 0; i < (nbytes + 15) / 16; i++) begin
      t = '0;
      d = '0;
      for (int j = 0; j < 16; j++) begin
        b = 8'($urandom);
        if (i * 16 + j < nbytes) begin
          t[127-8*j -: 8] = b;
          d[127-8*j -: 8] = b;
        end else begin
          d[127-8*j -: 8] = 8'($urandom);
        end
      end
      if (is_ct) ct_true.push_back(t);
      else aad_true.push_back(t);
      drv_blks.push_back(d);
    end
  endtask

  task automatic build_msg(input int na, input int nc);
    aad_true.delete();
    ct_true.delete();
    drv_blks.delete();
    add_phase(na, 1'b0);
    add_phase(nc, 1'b1);
  endtask

  // Starts a message, streams drv_blks and waits (bounded) for done.
  task automatic drive_msg(input logic [63:0] ab, input logic [63:0] cb,
                           input logic [127:0] ek, input logic [127:0] tin,
                           input bit gaps, input bit hold_tail, input bit inj_start);
    int k;
    res_tmo = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.aad_bits = ab; bus.ct_bits = cb; bus.ek_y0 = ek; bus.tag_in = tin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    foreach (drv_blks[i]) begin
      if (gaps) begin
        bus.blk_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      bus.blk_valid = 1'b1;
      bus.blk_data  = drv_blks[i];
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.blk_ready && k < 3000);
      if (!bus.blk_ready) res_tmo = 1'b1;
      @(posedge clk); #1;
      bus.blk_data = {$urandom, $urandom, $urandom, $urandom};
      if (inj_start && i == 0) begin
        bus.start = 1'b1; bus.aad_bits = {$urandom, $urandom}; bus.ct_bits = {$urandom, $urandom};
        bus.ek_y0 = ~ek; bus.tag_in = ~tin;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    if (!hold_tail) bus.blk_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.done && k < 3000);
    if (!bus.done) res_tmo = 1'b1;
    res_lat  = cyc - last_md_cyc;
    res_tout = bus.tag_out;
    res_tok  = bus.tag_ok;
    res_busy = bus.busy;
    @(negedge clk);
    res_again = bus.done;
    @(posedge clk); #1;
    bus.blk_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.busy, bus.done, bus.blk_ready, bus.mul_start, bus.tag_ok} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {bus.busy, bus.done, bus.blk_ready, bus.mul_start, bus.tag_ok}); end
    n_cmp++; if (bus.mul_x !== 128'd0) begin n_err++; $display("FAIL reset_mul_x: got %h want 0", bus.mul_x); end
    n_cmp++; if (bus.mul_y_prev !== 128'd0) begin n_err++; $display("FAIL reset_y_prev: got %h want 0", bus.mul_y_prev); end
    n_cmp++; if (bus.tag_out !== 128'd0) begin n_err++; $display("FAIL reset_tag_out: got %h want 0", bus.tag_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_empty;
    int ms0, rd0;
    mul_mode = 0; mul_lat = 20; h_key = C_H;
    build_msg(0, 0);
    ms0 = ms_cnt; rd0 = rdy_cnt;
    drive_msg(64'd0, 64'd0, C_EK, C_EK, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (res_tmo !== 1'b0) begin n_err++; $display("FAIL empty_timeout: got %b want 0", res_tmo); end
    n_cmp++; if (ms_cnt - ms0 !== 1) begin n_err++; $display("FAIL empty_mul_starts: got %0d want 1", ms_cnt - ms0); end
    n_cmp++; if (rdy_cnt - rd0 !== 0) begin n_err++; $display("FAIL empty_blk_ready: got %0d want 0", rdy_cnt - rd0); end
    n_cmp++; if (res_tout !== C_EK) begin n_err++; $display("FAIL empty_tag_out: got %h want %h", res_tout, C_EK); end
    n_cmp++; if (res_tok !== 1'b1) begin n_err++; $display("FAIL empty_tag_ok: got %b want 1", res_tok); end
    n_cmp++; if (res_busy !== 1'b0) begin n_err++; $display("FAIL empty_busy_at_done: got %b want 0", res_busy); end
    n_cmp++; if (res_again !== 1'b0) begin n_err++; $display("FAIL empty_done_pulse: got %b want 0", res_again); end
  endtask

  task automatic test_nist2;
    int a0;
    mul_mode = 0; mul_lat = 128; h_key = C_H;
    aad_true.delete(); ct_true.delete(); drv_blks.delete();
    ct_true.push_back(C_CT2); drv_blks.push_back(C_CT2);
    a0 = acc_cnt;
    drive_msg(64'd0, 64'd128, C_EK, C_TAG2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (res_tmo !== 1'b0) begin n_err++; $display("FAIL tc2_timeout: got %b want 0", res_tmo); end
    n_cmp++; if (res_tout !== C_TAG2) begin n_err++; $display("FAIL tc2_tag_out: got %h want %h", res_tout, C_TAG2); end
    n_cmp++; if (res_tok !== 1'b1) begin n_err++; $display("FAIL tc2_tag_ok: got %b want 1", res_tok); end
    n_cmp++; if (res_lat !== 2) begin n_err++; $display("FAIL tc2_done_latency: got %0d want 2", res_lat); end
    n_cmp++; if (acc_cnt - a0 !== 1) begin n_err++; $display("FAIL tc2_accepts: got %0d want 1", acc_cnt - a0); end
    // same message, corrupted received tag
    mul_lat = 7;
    drive_msg(64'd0, 64'd128, C_EK, C_TAG2 ^ 128'd1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (res_tok !== 1'b0) begin n_err++; $display("FAIL tc2bad_tag_ok: got %b want 0", res_tok); end
    n_cmp++; if (res_tout !== C_TAG2) begin n_err++; $display("FAIL tc2bad_tag_out: got %h want %h", res_tout, C_TAG2); end
  endtask

  task automatic test_stub_partial;
    int a0, m0;
    logic [127:0] tin, exp;
    mul_mode = 1; mul_lat = 5;
    aad_true.delete(); ct_true.delete(); drv_blks.delete();
    aad_true.push_back({128{1'b1}});
    aad_true.push_back(128'hffffffff_00000000_00000000_00000000);
    ct_true.push_back(128'hff000000_00000000_00000000_00000000);
    repeat (3) drv_blks.push_back({128{1'b1}});
    tin = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_ghash(1, h_key, 64'd160, 64'd8) ^ tin;   // ek_y0 chosen equal to tin
    a0 = acc_cnt; m0 = mx_log.size();
    drive_msg(64'd160, 64'd8, tin, tin, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (acc_cnt - a0 !== 3) begin n_err++; $display("FAIL stub_accepts: got %0d want 3", acc_cnt - a0); end
    n_cmp++; if (mx_log.size() - m0 !== 4) begin n_err++; $display("FAIL stub_mul_starts: got %0d want 4", mx_log.size() - m0); end
    else begin
      n_cmp++; if (mx_log[m0+1] !== 128'hffffffff_00000000_00000000_00000000) begin
        n_err++; $display("FAIL stub_aad2_mask: got %h want ffffffff000000000000000000000000", mx_log[m0+1]); end
      n_cmp++; if (mx_log[m0+2] !== 128'hff000000_00000000_00000000_00000000) begin
        n_err++; $display("FAIL stub_ct_mask: got %h want ff000000000000000000000000000000", mx_log[m0+2]); end
      n_cmp++; if (mx_log[m0+3] !== 128'h00000000000000a0_0000000000000008) begin
        n_err++; $display("FAIL stub_len_blk: got %h want 00000000000000a00000000000000008", mx_log[m0+3]); end
    end
    n_cmp++; if (res_tout !== exp) begin n_err++; $display("FAIL stub_tag_out: got %h want %h", res_tout, exp); end
  endtask

  task automatic test_edges;
    int a0, m0, nb;
    logic [127:0] ek, exp;
    bit seq_ok;
    mul_mode = 0; mul_lat = 3; h_key = {$urandom, $urandom, $urandom, $urandom};
    build_msg(27, 20);
    ek  = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_ghash(0, h_key, 64'd216, 64'd160) ^ ek;
    nb  = aad_true.size() + ct_true.size();
    a0 = acc_cnt; m0 = mx_log.size();
    drive_msg(64'd216, 64'd160, ek, exp, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (acc_cnt - a0 !== nb) begin n_err++; $display("FAIL edge_accepts: got %0d want %0d", acc_cnt - a0, nb); end
    seq_ok = (mx_log.size() - m0 == nb + 1);
    for (int i = 0; seq_ok && i < nb; i++)
      seq_ok = (mx_log[m0+i] === ((i < aad_true.size()) ? aad_true[i] : ct_true[i - aad_true.size()]));
    if (seq_ok) seq_ok = (mx_log[m0+nb] === {64'd216, 64'd160});
    n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL edge_mul_x_seq: got mismatching sequence (%0d starts) want %0d", mx_log.size() - m0, nb + 1); end
    n_cmp++; if (res_tout !== exp) begin n_err++; $display("FAIL edge_tag_out: got %h want %h", res_tout, exp); end
    n_cmp++; if (res_tok !== 1'b1) begin n_err++; $display("FAIL edge_tag_ok: got %b want 1", res_tok); end
  endtask

  task automatic test_reset_mid;
    int k, d0;
    logic [127:0] ek, exp;
    mul_mode = 0; mul_lat = 30; h_key = {$urandom, $urandom, $urandom, $urandom};
    build_msg(0, 40);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.aad_bits = 64'd0; bus.ct_bits = 64'd320;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.blk_valid = 1'b1; bus.blk_data = drv_blks[0];
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.blk_ready && k < 100);
    n_cmp++; if (bus.blk_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_first_ready: got %b want 1", bus.blk_ready); end
    @(posedge clk); #1;
    rst_n = 1'b0; bus.blk_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.busy, bus.done, bus.blk_ready, bus.mul_start, bus.tag_ok} !== 5'b0) begin
      n_err++; $display("FAIL rstmid_ctrl: got %b want 00000", {bus.busy, bus.done, bus.blk_ready, bus.mul_start, bus.tag_ok}); end
    n_cmp++; if ({bus.mul_x, bus.mul_y_prev, bus.tag_out} !== 384'd0) begin
      n_err++; $display("FAIL rstmid_data: got %h want 0", {bus.mul_x, bus.mul_y_prev, bus.tag_out}); end
    d0 = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
    ek  = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_ghash(0, h_key, 64'd0, 64'd320) ^ ek;
    drive_msg(64'd0, 64'd320, ek, exp, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (res_tout !== exp || res_tok !== 1'b1) begin
      n_err++; $display("FAIL rstmid_after: got %h/%b want %h/1", res_tout, res_tok, exp); end
  endtask

  task automatic test_random;
    int na, nc, a0, m0, nb;
    logic [127:0] ek, gh, tin;
    bit flip;
    for (int it = 0; it < 6; it++) begin
      mul_mode = 0; mul_lat = $urandom_range(1, 6); h_key = {$urandom, $urandom, $urandom, $urandom};
      na = $urandom_range(0, 40); nc = $urandom_range(0, 50);
      build_msg(na, nc);
      nb   = aad_true.size() + ct_true.size();
      ek   = {$urandom, $urandom, $urandom, $urandom};
      gh   = ref_ghash(0, h_key, 64'(na * 8), 64'(nc * 8)) ^ ek;
      flip = 1'($urandom_range(0, 1));
      tin  = flip ? (gh ^ (128'd1 << $urandom_range(0, 127))) : gh;
      a0 = acc_cnt; m0 = mx_log.size();
      drive_msg(64'(na * 8), 64'(nc * 8), ek, tin, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (res_tout !== gh) begin n_err++; $display("FAIL rand%0d_tag_out: got %h want %h", it, res_tout, gh); end
      n_cmp++; if (res_tok !== !flip) begin n_err++; $display("FAIL rand%0d_tag_ok: got %b want %b", it, res_tok, !flip); end
      n_cmp++; if (acc_cnt - a0 !== nb) begin n_err++; $display("FAIL rand%0d_accepts: got %0d want %0d", it, acc_cnt - a0, nb); end
      n_cmp++; if (mx_log.size() - m0 !== nb + 1) begin
        n_err++; $display("FAIL rand%0d_mul_starts: got %0d want %0d", it, mx_log.size() - m0, nb + 1); end
    end
  endtask

`ifdef GCM_TAG_TRUNC_EN
  task automatic test_trunc;
    logic [127:0] tin;
    mul_mode = 0; mul_lat = 9; h_key = C_H;
    aad_true.delete(); ct_true.delete(); drv_blks.delete();
    ct_true.push_back(C_CT2); drv_blks.push_back(C_CT2);
    tin = C_TAG2 ^ 128'h00000000_00000000_00000000_a5a5a5a5;
    bus.tag_bytes = 5'd12;
    drive_msg(64'd0, 64'd128, C_EK, tin, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (res_tok !== 1'b1) begin n_err++; $display("FAIL trunc12_tag_ok: got %b want 1", res_tok); end
    bus.tag_bytes = 5'd16;
    drive_msg(64'd0, 64'd128, C_EK, tin, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (res_tok !== 1'b0) begin n_err++; $display("FAIL trunc16_tag_ok: got %b want 0", res_tok); end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.blk_valid = 1'b0; bus.blk_data = '0;
    bus.ek_y0 = '0; bus.tag_in = '0; bus.aad_bits = '0; bus.ct_bits = '0;
`ifdef GCM_TAG_TRUNC_EN
    bus.tag_bytes = 5'd16;
`endif
    test_reset();
    test_empty();
    test_nist2();
    test_stub_partial();
    test_edges();
    test_reset_mid();
    test_random();
`ifdef GCM_TAG_TRUNC_EN
    test_trunc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/gcm_tag_verify.md
# gcm_tag_verify

Receive-side GCM authentication sequencer. Streams AAD and ciphertext blocks into the team's bit-serial GHASH multiplier over a start/done interface, appends the length block, and forms the tag as GHASH ⊕ E(K,Y0). It then compares that tag against the received tag. It sits beside the decrypt datapath: the CTR core supplies E(K,Y0), and the multiplier supplies the GF(2^128) products.

## Interface
- LEN_W, 64, width of the aad_bits and ct_bits length inputs (bits).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse. Latches ek_y0, tag_in, aad_bits and ct_bits. Ignored unless busy=0.
- ek_y0  in  128  E(K,Y0).
- tag_in  in  128  received tag.
- aad_bits  in  LEN_W  AAD length in bits. Must be a multiple of 8.
- ct_bits  in  LEN_W  ciphertext length in bits. Must be a multiple of 8.
- blk_valid  in  1  block available.
- blk_ready  out  1  block accepted on the cycle where blk_valid && blk_ready.
- blk_data  in  128  block; bit 127 is the first bit.
- mul_start  out  1  one-cycle pulse to the multiplier.
- mul_x  out  128  masked block, or the length block.
- mul_y_prev  out  128  running accumulator Y.
- mul_done  in  1  multiplier completion pulse.
- mul_y  in  128  multiplier result, valid while mul_done=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of message.
- tag_out  out  128  computed tag, held until the next start.
- tag_ok  out  1  tag_out matches tag_in, held until the next start.

## Operation
- States: IDLE, AAD_WAIT, AAD_MUL, CT_WAIT, CT_MUL, LEN_MUL, FIN.
- On start in IDLE:
  - Y <= 0.
  - n_aad = ceil(aad_bits/128), n_ct = ceil(ct_bits/128).
  - Clear tag_ok and tag_out.
  - Next state is AAD_WAIT if n_aad>0, else CT_WAIT if n_ct>0, else LEN_MUL.
- blk_ready=1 only in AAD_WAIT and CT_WAIT.
- On block accept:
  - Register mul_x = blk_data with bits below the remaining length zeroed. This applies only to the final block when len mod 128 ≠ 0; the high (len mod 128) bits are kept.
  - Pulse mul_start the next cycle, with mul_y_prev = Y.
  - Move to the matching *_MUL state.
- In *_MUL, on mul_done:
  - Y <= mul_y and decrement the block count.
  - Next state: the same *_WAIT if blocks remain; else the next phase (CT_WAIT, or LEN_MUL if n_ct=0).
- LEN_MUL:
  - On entry, pulse mul_start with mul_x = {aad_bits zero-extended to 64, ct_bits zero-extended to 64}.
  - On mul_done, latch the result and go to FIN.
- FIN (one cycle):
  - tag_out <= mul_y_latched ⊕ ek_y0.
  - tag_ok <= compare result.
  - done=1; return to IDLE.
- mul_done outside a *_MUL/LEN_MUL state is ignored. Blocks offered in other states are not accepted.
- A start while busy is ignored; latched inputs are not disturbed.
- Lengths wider than 64 bits are truncated to 64 in the length block only.

## Timing
- Reset value of every output is 0. Reset mid-message aborts to IDLE with no done pulse.
- Start accepted at cycle S: busy=1 from S+1, and blk_ready=1 from S+1 when the first phase is a *_WAIT state.
- Block accepted at T: mul_start at T+1. If mul_done arrives at D, the earliest next blk_ready is D+1.
- Multiplier latency is arbitrary; the block waits indefinitely for mul_done.
- Length-block mul_done at D: done, tag_out and tag_ok all valid at D+2.
- busy falls in the same cycle done rises.
- Throughput with the 128-cycle multiplier is about 130 cycles per block.

## Configuration
- GCM_TAG_TRUNC_EN defined:
  - Adds input tag_bytes[4:0], latched at start; legal values are 12–16.
  - tag_ok compares only the top 8·tag_bytes bits.
  - Illegal values compare all 128 bits.
- GCM_TAG_TRUNC_EN undefined: the port is absent, and tag_ok is a full 128-bit compare.

## Test plan
- Empty message (K=0): aad_bits=0, ct_bits=0, ek_y0=tag_in=58e2fccefa7e3061367f1d57a4e7455a, with the real multiplier and H=66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Required: exactly one mul_start, blk_ready never high, tag_out=58e2…455a, tag_ok=1.
- NIST test case 2: ct_bits=128, blk_data=0388dace60b6a392f328c2b971b2fe78, same ek_y0, tag_in=ab6e47d42cec13bdf53a67b21257bddf.
  - Required: tag_out equals tag_in, tag_ok=1, done at D+2.
- Same as test case 2 with tag_in bit 0 flipped.
  - Required: tag_ok=0, tag_out unchanged.
- aad_bits=160, ct_bits=8, all blocks 0xFF…FF, behind a stub multiplier that echoes mul_x⊕mul_y_prev after 5 cycles.
  - Required: three blocks accepted.
  - mul_x of AAD block 2 = ffffffff followed by 24 zero hex digits.
  - mul_x of the CT block = ff followed by 30 zero hex digits.
  - Length block = 00000000000000a00000000000000008.
- Edge cases:
  - blk_valid held high while in *_MUL: no accept.
  - start pulsed mid-message: ignored.
  - rst_n low during CT_MUL: all outputs 0, no done pulse. A subsequent start then completes normally.
- With GCM_TAG_TRUNC_EN and tag_bytes=12, a test case 2 tag_in with its low 32 bits corrupted.
  - Required: tag_ok=1. With tag_bytes=16 the same stimulus gives tag_ok=0.
